// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_cell.sv
// One-bit full subtractor: d = x - y - z (mod 2), b = borrow out.
module full_subtractor_cell (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic d,
  output logic b
);

  assign d = x ^ y ^ z;
  assign b = (~x & y) | (~x & z) | (y & z);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock through a single
// full-subtractor cell with a registered borrow and a start/busy/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  state_t             state;
  state_t             state_nxt;
  logic [WIDTH-1:0]   a_sr;
  logic [WIDTH-1:0]   b_sr;
  logic [WIDTH-1:0]   diff_sr;
  logic [WIDTH-1:0]   diff_nxt;
  logic [CNT_W-1:0]   cnt;
  logic               borrow;
  logic               bout_r;
  logic               cell_d;
  logic               cell_b;
  logic               last_bit;

  full_subtractor_cell u_cell (
    .x (a_sr[0]),
    .y (b_sr[0]),
    .z (borrow),
    .d (cell_d),
    .b (cell_b)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last_bit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // New difference bit enters at the MSB so the LSB lands in bit 0 after WIDTH shifts.
  always_comb begin
    diff_nxt            = diff_sr >> 1;
    diff_nxt[WIDTH-1]   = cell_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr    <= '0;
      b_sr    <= '0;
      diff_sr <= '0;
      cnt     <= '0;
      borrow  <= 1'b0;
      bout_r  <= 1'b0;
    end else if (state == IDLE && start) begin
      a_sr   <= a;
      b_sr   <= b;
      borrow <= bin;
      cnt    <= '0;
    end else if (state == RUN) begin
      a_sr    <= a_sr >> 1;
      b_sr    <= b_sr >> 1;
      diff_sr <= diff_nxt;
      borrow  <= cell_b;
      bout_r  <= cell_b;
      cnt     <= cnt + CNT_W'(1);
    end
  end

  assign diff = diff_sr;
  assign bout = bout_r;

endmodule
